l0_fill_ctrl: RTL and testbench

- Fill controller directly upstream of the L0 row-FIFO buffer.
- Streams `len` activation vectors (row*bw bits each) from the activation SRAM, starting at `base_addr`, into L0.
- Handles the SRAM's 1-cycle read latency and L0 backpressure (`o_ready`) with a small skid FIFO.
- No data is lost or duplicated, and it sustains one vector per cycle when L0 is ready.

---
 rtl/l0_fill_pkg.sv | 14 +
 rtl/fill_skid_fifo.sv | 60 ++++++
 rtl/l0_fill_ctrl.sv | 148 ++++++++++++++
 tb/tb_l0_fill_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l0_fill_pkg.sv
// Shared types and sizing for the L0 fill controller.
package l0_fill_pkg;

    localparam int unsigned SKID_DEPTH = 4;
    localparam int unsigned SKID_PTR_W = $clog2(SKID_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StFin
    } fill_state_e;

endpackage

// File: rtl/fill_skid_fifo.sv
// Small synchronous FIFO absorbing SRAM read data while L0 applies backpressure.
module fill_skid_fifo #(
    parameter int unsigned width = 32,
    parameter int unsigned depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [width-1:0]         wdata,
    input  logic                     pop,
    output logic [width-1:0]         head,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);

    localparam int unsigned PW = $clog2(depth);
    localparam int unsigned CW = PW + 1;

    logic [width-1:0] mem_q [depth];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    assign empty  = (count_q == '0);
    assign do_pop = pop & ~empty;
    assign head   = mem_q[rptr_q];
    assign count  = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // The upstream credit check must make overflow impossible.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !do_pop && (count_q == CW'(depth))));
        end
    end

endmodule

// File: rtl/l0_fill_ctrl.sv
// Streams len vectors from the activation SRAM into L0, hiding the SRAM read
// latency and L0 backpressure behind a credit-checked skid FIFO.
module l0_fill_ctrl
    import l0_fill_pkg::*;
#(
    parameter int unsigned row        = 8,
    parameter int unsigned bw         = 4,
    parameter int unsigned addr_w     = 11,
    parameter int unsigned skid_depth = SKID_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_w-1:0]     base_addr,
    input  logic [addr_w:0]       len,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [addr_w-1:0]     sram_a,
    input  logic [row*bw-1:0]     sram_q,
    output logic                  l0_wr,
    output logic [row*bw-1:0]     l0_in,
    input  logic                  l0_ready
);

    localparam int unsigned DW  = row * bw;
    localparam int unsigned LW  = addr_w + 1;
    localparam int unsigned CW  = $clog2(skid_depth) + 1;
    localparam int unsigned CRW = CW + 2;

    fill_state_e       state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [LW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [addr_w-1:0] base_q, base_d;
    logic [addr_w-1:0] sram_a_q, sram_a_d;
    logic              sram_cen_q, sram_cen_d;
    logic              rvalid_q;

    logic              skid_empty;
    logic [DW-1:0]     skid_head;
    logic [CW-1:0]     skid_count;
    logic              read_active;
    logic [CRW-1:0]    credit_sum;
    logic              credit_ok;

    fill_skid_fifo #(
        .width (DW),
        .depth (skid_depth)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (rvalid_q),
        .wdata (sram_q),
        .pop   (l0_wr),
        .head  (skid_head),
        .empty (skid_empty),
        .count (skid_count)
    );

    assign busy     = (state_q == StRead) || (state_q == StDrain);
    assign done     = (state_q == StFin);
    assign sram_cen = sram_cen_q;
    assign sram_wen = 1'b1;
    assign sram_a   = sram_a_q;
    assign l0_wr    = ~skid_empty & l0_ready & busy;
    assign l0_in    = skid_empty ? '0 : skid_head;

    // Entries held plus reads still in flight must leave room for one more.
    assign read_active = ~sram_cen_q;
    assign credit_sum  = CRW'(skid_count) + CRW'(read_active) + CRW'(rvalid_q) + CRW'(1);
    assign credit_ok   = (credit_sum <= CRW'(skid_depth));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        base_d     = base_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q + LW'(l0_wr);
        sram_cen_d = 1'b1;
        sram_a_d   = sram_a_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d    = len;
                    base_d   = base_addr;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    if (len == '0) begin
                        state_d = StFin;
                    end else begin
                        // First read goes out on the accepting edge.
                        sram_cen_d = 1'b0;
                        sram_a_d   = base_addr;
                        rd_cnt_d   = LW'(1);
                        state_d    = (len == LW'(1)) ? StDrain : StRead;
                    end
                end
            end
            StRead: begin
                if ((rd_cnt_q < len_q) && credit_ok) begin
                    sram_cen_d = 1'b0;
                    sram_a_d   = base_q + rd_cnt_q[addr_w-1:0];
                    rd_cnt_d   = rd_cnt_q + LW'(1);
                end
                if (rd_cnt_d == len_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wr_cnt_d == len_q) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            base_q     <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            sram_cen_q <= 1'b1;
            sram_a_q   <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            base_q     <= base_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            sram_cen_q <= sram_cen_d;
            sram_a_q   <= sram_a_d;
            rvalid_q   <= ~sram_cen_q;
        end
    end

endmodule

// File: tb/tb_l0_fill_ctrl.sv
// Randomized bench for l0_fill_ctrl with a cycle-level behavioural reference model.
module tb_l0_fill_ctrl;

    localparam int AW   = 11;
    localparam int LW   = 12;
    localparam int DW   = 32;
    localparam int NMEM = 2048;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, sram_cen, sram_wen, l0_wr;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_q = '0;
    logic [DW-1:0] l0_in;
    logic          l0_ready = 1'b1;

    logic [DW-1:0] mem [NMEM];

    l0_fill_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_q    (sram_q),
        .l0_wr     (l0_wr),
        .l0_in     (l0_in),
        .l0_ready  (l0_ready)
    );

    always #5 clk = ~clk;

    // SRAM with one-cycle read latency; junk on the bus when not reading.
    always @(posedge clk) begin
        if (!sram_cen) sram_q <= mem[sram_a];
        else sram_q <= $urandom;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: counts of reads/writes per transaction.
    bit armed = 0;
    bit m_busy = 0, m_done = 0, m_cen = 0, m_after_rst = 0;
    int m_len = 0, m_base = 0, m_a = 0;
    int m_rd1 = 0;  // reads issued through previous cycle
    int m_rd2 = 0;  // reads issued through the cycle before that
    int m_wr = 0;   // writes completed before this cycle
    int rel = 0;    // cycle index relative to the last accepted start

    // Per-transaction logs for directed literal checks.
    int            first_cen, last_cen, first_wr, last_wr, done_cyc, done_cnt, wr_total;
    int            addr_log[$];
    logic [DW-1:0] wr_log[$];

    int  rmode = 0;  // 0: ready high, 1: random, 2: low in cycles 4..9

    task automatic clear_logs();
        first_cen = -1; last_cen = -1; first_wr = -1; last_wr = -1;
        done_cyc = -1; done_cnt = 0; wr_total = 0;
        addr_log.delete();
        wr_log.delete();
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_cen = 0; m_a = 0;
        m_rd1 = 0; m_rd2 = 0; m_wr = 0; m_after_rst = 1;
    endtask

    always @(negedge clk) begin
        int rd_c0, wr_nx;
        bit exp_wr, idle_now, cen_nx, done_nx, busy_nx;
        if (!armed) begin
            if (reset) begin
                armed = 1;
                model_reset();
                clear_logs();
            end
        end else begin
            exp_wr = m_busy && l0_ready && ((m_rd2 - m_wr) > 0);
            chk("sram_wen", 64'(sram_wen), 64'd1);
            chk("sram_cen", 64'(sram_cen), 64'(!m_cen));
            chk("sram_a", 64'(sram_a), 64'(m_a));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("l0_wr", 64'(l0_wr), 64'(exp_wr));
            if (exp_wr && l0_wr)
                chk("l0_in", 64'(l0_in), 64'(mem[(m_base + m_wr) % NMEM]));
            if (m_after_rst) chk("l0_in_after_reset", 64'(l0_in), 64'd0);

            if (!sram_cen) begin
                addr_log.push_back(int'(sram_a));
                last_cen = rel;
                if (first_cen < 0) first_cen = rel;
            end
            if (l0_wr) begin
                wr_log.push_back(l0_in);
                wr_total++;
                last_wr = rel;
                if (first_wr < 0) first_wr = rel;
            end
            if (done) begin
                done_cyc = rel;
                done_cnt++;
            end

            if (reset) begin
                model_reset();
                rel++;
            end else begin
                m_after_rst = 0;
                idle_now = !m_busy && !m_done;
                rd_c0 = m_rd1 + (m_cen ? 1 : 0);
                wr_nx = m_wr + (exp_wr ? 1 : 0);
                // Reads issued but not yet written, plus the new one, fit in 4 slots.
                cen_nx = m_busy && (rd_c0 < m_len) && ((rd_c0 - m_wr) <= 3);
                if (cen_nx) m_a = (m_base + rd_c0) % NMEM;
                done_nx = m_busy && exp_wr && (wr_nx == m_len);
                busy_nx = m_busy && !done_nx;
                m_rd2 = m_rd1;
                m_rd1 = rd_c0;
                m_wr = wr_nx;
                rel++;
                if (idle_now && start) begin
                    m_len = int'(len);
                    m_base = int'(base_addr);
                    m_rd1 = 0; m_rd2 = 0; m_wr = 0;
                    rel = 1;
                    clear_logs();
                    if (len == '0) begin
                        done_nx = 1;
                    end else begin
                        busy_nx = 1;
                        cen_nx = 1;
                        m_a = int'(base_addr);
                    end
                end
                m_cen = cen_nx;
                m_busy = busy_nx;
                m_done = done_nx;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: l0_ready = 1'b1;
                1: l0_ready = ($urandom_range(0, 3) != 0);
                default: l0_ready = !(rel >= 4 && rel <= 9);
            endcase
        end
    end

    task automatic run_fill(input int b, input int l, input int mode, input int extra_at);
        bit got;
        rmode = mode;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = AW'(b);
        len = LW'(l);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = AW'($urandom);
        len = LW'($urandom_range(0, 4095));
        got = 0;
        for (int i = 0; i < 20000 && !got; i++) begin
            if (extra_at != 0 && rel == extra_at) begin
                start = 1'b1;
                len = LW'(3);
            end else begin
                start = 1'b0;
            end
            if (done) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        chk("done_within_bound", 64'(got), 64'd1);
        @(negedge clk); #1;
    endtask

    initial begin
        int b;
        int l;
        int exp_wrap[4];
        for (int a = 0; a < NMEM; a++) mem[a] = DW'(a);
        clear_logs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_cen", 64'(sram_cen), 64'd1);
        chk("reset_a", 64'(sram_a), 64'd0);
        chk("reset_l0_wr", 64'(l0_wr), 64'd0);
        chk("reset_l0_in", 64'(l0_in), 64'd0);

        // Basic fill with identity memory.
        run_fill(16, 4, 0, 0);
        chk("basic_first_cen", 64'(first_cen), 64'd1);
        chk("basic_last_cen", 64'(last_cen), 64'd4);
        chk("basic_first_wr", 64'(first_wr), 64'd3);
        chk("basic_last_wr", 64'(last_wr), 64'd6);
        chk("basic_done_cyc", 64'(done_cyc), 64'd7);
        chk("basic_wr_total", 64'(wr_total), 64'd4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            chk("basic_data", 64'(wr_log[i]), 64'(16 + i));

        for (int a = 0; a < NMEM; a++) mem[a] = $urandom;

        // Backpressure: ready low in cycles 4..9.
        run_fill(300, 8, 2, 0);
        chk("bp_wr_total", 64'(wr_total), 64'd8);
        chk("bp_reads", 64'(addr_log.size()), 64'd8);
        chk("bp_last_cen", 64'(last_cen), 64'd14);
        chk("bp_done_cyc", 64'(done_cyc), 64'd17);

        // Address wrap.
        exp_wrap = '{2046, 2047, 0, 1};
        run_fill(2046, 4, 0, 0);
        chk("wrap_reads", 64'(addr_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk("wrap_addr", 64'(addr_log[i]), 64'(exp_wrap[i]));

        // Zero length.
        run_fill(77, 0, 0, 0);
        chk("zero_done_cyc", 64'(done_cyc), 64'd1);
        chk("zero_wr_total", 64'(wr_total), 64'd0);
        chk("zero_reads", 64'(addr_log.size()), 64'd0);

        // Reset in cycle 4 of a len=8 fill.
        rmode = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(500); len = LW'(8);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && rel != 4; i++) begin
            @(posedge clk); #1;
        end
        chk("reset_mid_reach", 64'(rel), 64'd4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_cen", 64'(sram_cen), 64'd1);
        chk("midrst_a", 64'(sram_a), 64'd0);
        chk("midrst_l0_wr", 64'(l0_wr), 64'd0);
        chk("midrst_l0_in", 64'(l0_in), 64'd0);
        for (int a = 0; a < NMEM; a++) mem[a] = $urandom;
        run_fill(900, 2, 0, 0);
        chk("postrst_wr_total", 64'(wr_total), 64'd2);

        // Start while busy is ignored.
        run_fill(1200, 6, 0, 3);
        chk("busy_start_wr_total", 64'(wr_total), 64'd6);
        chk("busy_start_done_cnt", 64'(done_cnt), 64'd1);

        // Randomized fills.
        for (int t = 0; t < 25; t++) begin
            b = $urandom_range(0, NMEM - 1);
            l = (t == 7) ? 2048 : $urandom_range(0, 24);
            run_fill(b, l, $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 2 : 0);
            chk("rand_wr_total", 64'(wr_total), 64'(l));
            chk("rand_done_cnt", 64'(done_cnt), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
